a_bus_cycle_ctrl: RTL and testbench

- A-bus access sequencer. It accepts CPU/DMA access requests, classifies each address into a mem_speed_type, and drives the A-bus address, /RD and /WR strobes and write data for 6, 8 or 12 master clocks.
- It returns an ack with the captured read data.
- It is the responder/timing end for the speed classes and the A-bus read targets defined in bus_pkg.

---
 rtl/bus_pkg.sv | 50 +++++
 rtl/a_bus_speed_decode.sv | 18 +
 rtl/a_bus_cycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_a_bus_cycle_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - A-bus speed classes, cycle lengths, FSM states and raw speed table
// Optional feature macro: SFC_REFRESH_EN (adds the REFRESH state)
package bus_pkg;

  typedef enum logic [1:0] {
    MEM_FAST  = 2'd0,
    MEM_SLOW  = 2'd1,
    MEM_XSLOW = 2'd2,
    MEM_VAR   = 2'd3
  } mem_speed_type;

  localparam int A_ADDR_CYCLES = 2;
  localparam int A_FAST_LEN    = 6;
  localparam int A_SLOW_LEN    = 8;
  localparam int A_XSLOW_LEN   = 12;
  localparam int A_REFRESH_LEN = 40;

`ifdef SFC_REFRESH_EN
  typedef enum logic [1:0] {
    A_IDLE    = 2'd0,
    A_ADDR    = 2'd1,
    A_STROBE  = 2'd2,
    A_REFRESH = 2'd3
  } a_state_t;
`else
  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_ADDR   = 2'd1,
    A_STROBE = 2'd2
  } a_state_t;
`endif

  // Raw table: MEM_VAR is left unresolved, memsel is applied by the caller.
  function automatic mem_speed_type a_speed_of(input logic [23:0] addr);
    logic [7:0]  bank;
    logic [15:0] off;
    bank = addr[23:16];
    off  = addr[15:0];
    if (bank[7:6] == 2'b01)      a_speed_of = MEM_SLOW;
    else if (bank[7:6] == 2'b11) a_speed_of = MEM_VAR;
    else if (off < 16'h2000)     a_speed_of = MEM_SLOW;
    else if (off < 16'h4000)     a_speed_of = MEM_FAST;
    else if (off < 16'h4200)     a_speed_of = MEM_XSLOW;
    else if (off < 16'h6000)     a_speed_of = MEM_FAST;
    else if (off < 16'h8000)     a_speed_of = MEM_SLOW;
    else if (bank[7])            a_speed_of = MEM_VAR;
    else                         a_speed_of = MEM_SLOW;
  endfunction

endpackage

// File: rtl/a_bus_speed_decode.sv
// rtl/a_bus_speed_decode.sv - combinational A-bus speed decode with VAR resolved by memsel
module a_bus_speed_decode
  import bus_pkg::*;
(
  input  logic [23:0]   addr,
  input  logic          memsel,
  output mem_speed_type speed
);

  mem_speed_type raw;

  always_comb begin
    raw   = a_speed_of(addr);
    speed = raw;
    if (raw == MEM_VAR) speed = memsel ? MEM_FAST : MEM_SLOW;
  end

endmodule

// File: rtl/a_bus_cycle_ctrl.sv
// rtl/a_bus_cycle_ctrl.sv - A-bus access sequencer: address setup, /RD or /WR strobe, ack
// Optional feature macro: SFC_REFRESH_EN (WRAM refresh stall)
module a_bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_CYCLES = A_ADDR_CYCLES,
  parameter int FAST_LEN    = A_FAST_LEN,
  parameter int SLOW_LEN    = A_SLOW_LEN,
  parameter int XSLOW_LEN   = A_XSLOW_LEN,
  parameter int REFRESH_LEN = A_REFRESH_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        req_write,
  input  logic [7:0]  req_wdata,
  input  logic        memsel,
  input  logic        refresh_req,
  output logic        ack,
  output logic [7:0]  ack_rdata,
  output logic [23:0] a_addr,
  output logic        a_rd_n,
  output logic        a_wr_n,
  output logic [7:0]  a_wdata,
  output logic        a_data_oe,
  input  logic [7:0]  a_rdata,
  output logic [1:0]  cur_speed,
  output logic        refresh_busy
);

  localparam logic [5:0] ADDR_LAST = 6'(ADDR_CYCLES - 1);

  a_state_t      state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [5:0]    last_q, last_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [7:0]    rdata_q, rdata_d;
  mem_speed_type speed_q, speed_d;
  mem_speed_type dec_speed;
  logic [5:0]    dec_last;
  logic          ack_c;
  logic          ready_slot;
  logic          refresh_hold;

  a_bus_speed_decode u_speed_decode (
    .addr   (req_addr),
    .memsel (memsel),
    .speed  (dec_speed)
  );

  always_comb begin
    case (dec_speed)
      MEM_FAST:  dec_last = 6'(FAST_LEN - 1);
      MEM_XSLOW: dec_last = 6'(XSLOW_LEN - 1);
      default:   dec_last = 6'(SLOW_LEN - 1);
    endcase
  end

`ifdef SFC_REFRESH_EN
  localparam logic [5:0] REFRESH_LAST = 6'(REFRESH_LEN - 1);

  logic pend_q, pend_d;

  assign refresh_hold = refresh_req | pend_q;
  assign refresh_busy = (state_q == A_REFRESH);

  // A pulse seen mid-access is parked until the access has acked.
  always_comb begin
    pend_d = pend_q;
    if (refresh_req && (state_q == A_ADDR || state_q == A_STROBE)) pend_d = 1'b1;
    if (ready_slot && refresh_hold) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end
`else
  localparam int unused_refresh_len = REFRESH_LEN;
  logic unused_refresh_req;
  assign unused_refresh_req = refresh_req;
  assign refresh_hold       = 1'b0;
  assign refresh_busy       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    speed_d    = speed_q;
    ack_c      = 1'b0;
    ready_slot = 1'b0;
    req_ready  = 1'b0;
    case (state_q)
      A_IDLE: ready_slot = 1'b1;
      A_ADDR: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == ADDR_LAST) state_d = A_STROBE;
      end
      A_STROBE: begin
        cnt_d = cnt_q + 6'd1;
        // Final strobe clock doubles as the ack clock and an accept slot.
        if (cnt_q == last_q) begin
          ack_c      = 1'b1;
          ready_slot = 1'b1;
          state_d    = A_IDLE;
          if (!write_q) rdata_d = a_rdata;
        end
      end
`ifdef SFC_REFRESH_EN
      A_REFRESH: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == REFRESH_LAST) state_d = A_IDLE;
      end
`endif
      default: state_d = A_IDLE;
    endcase

    if (ready_slot) begin
      if (refresh_hold) begin
`ifdef SFC_REFRESH_EN
        state_d = A_REFRESH;
        cnt_d   = '0;
`endif
      end else begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = A_ADDR;
          cnt_d   = '0;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          speed_d = dec_speed;
          last_d  = dec_last;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      speed_q <= MEM_FAST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      speed_q <= speed_d;
    end
  end

  assign ack       = ack_c;
  assign ack_rdata = (ack_c && !write_q) ? a_rdata : rdata_q;
  assign a_addr    = addr_q;
  assign a_wdata   = wdata_q;
  assign a_rd_n    = !((state_q == A_STROBE) && !write_q);
  assign a_wr_n    = !((state_q == A_STROBE) && write_q);
  assign a_data_oe = write_q && ((state_q == A_ADDR) || (state_q == A_STROBE));
  assign cur_speed = speed_q;

endmodule

// File: tb/tb_a_bus_cycle_ctrl.sv
// tb/tb_a_bus_cycle_ctrl.sv - scoreboard bench for a_bus_cycle_ctrl
module tb_a_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        memsel = 1'b0;
  logic        refresh_req = 1'b0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, ack, a_rd_n, a_wr_n, a_data_oe, refresh_busy;
  logic [7:0]  ack_rdata, a_wdata, a_rdata;
  logic [23:0] a_addr;
  logic [1:0]  cur_speed;

  a_bus_cycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .memsel       (memsel),
    .refresh_req  (refresh_req),
    .ack          (ack),
    .ack_rdata    (ack_rdata),
    .a_addr       (a_addr),
    .a_rd_n       (a_rd_n),
    .a_wr_n       (a_wr_n),
    .a_wdata      (a_wdata),
    .a_data_oe    (a_data_oe),
    .a_rdata      (a_rdata),
    .cur_speed    (cur_speed),
    .refresh_busy (refresh_busy)
  );

  // Bus slave: read data is bank ^ offset-hi ^ offset-lo ^ 5A.
  assign a_rdata = a_addr[23:16] ^ a_addr[15:8] ^ a_addr[7:0] ^ 8'h5A;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        ms;
    logic [1:0]  speed;
    int          len;
    logic [7:0]  rdata;
    logic        b2b;
    logic        tog;
  } vec_t;

  typedef struct {
    int          ack_cyc;
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic [1:0]  speed;
    int          len;
    logic [7:0]  rdata;
  } exp_t;

  exp_t q[$];
  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wr_cnt = 0, oe_cnt = 0, bus_bad = 0;
  int busy_cnt = 0, busy_rdy = 0, ack_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [23:0] addr, input logic wr, input logic [7:0] wdata,
                      input logic ms, input logic [1:0] speed, input int len,
                      input logic [7:0] rdata, input logic b2b, input logic tog);
    vec_t v;
    v.addr = addr; v.wr = wr; v.wdata = wdata; v.ms = ms; v.speed = speed;
    v.len = len; v.rdata = rdata; v.b2b = b2b; v.tog = tog;
    vq.push_back(v);
  endtask

  task automatic send(input vec_t v, output int hs);
    exp_t e;
    logic got;
    got = 1'b0;
    hs = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.wr;
    req_wdata = v.wdata;
    memsel    = v.ms;
    for (int n = 0; n < 200 && !got; n++) begin
      #1;
      if (req_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout addr=%06h ready=%0b expected=1", v.addr, req_ready);
      req_valid = 1'b0;
    end else begin
      hs = cyc;
      e.ack_cyc = cyc + v.len;
      e.addr = v.addr; e.wr = v.wr; e.wdata = v.wdata;
      e.speed = v.speed; e.len = v.len; e.rdata = v.rdata;
      q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: accumulates per-access bus activity, compares on each ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        rd_cnt = 0; wr_cnt = 0; oe_cnt = 0; bus_bad = 0;
      end else begin
        if (!a_rd_n) rd_cnt++;
        if (!a_wr_n) wr_cnt++;
        if (a_data_oe) oe_cnt++;
        if ((!a_rd_n || !a_wr_n) && q.size() > 0) begin
          if (a_addr !== q[0].addr) bus_bad++;
          if (!a_wr_n && a_wdata !== q[0].wdata) bus_bad++;
        end
        if (refresh_busy) busy_cnt++;
        if (refresh_busy && req_ready) busy_rdy++;
        if (ack) begin
          ack_total++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack cycle=%0d ack=1 expected=0", cyc);
          end else begin
            e = q.pop_front();
            chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
            chk("ack_rdata", 32'(ack_rdata), 32'(e.rdata));
            chk("cur_speed", 32'(cur_speed), 32'(e.speed));
            chk("rd_strobe_len", 32'(rd_cnt), e.wr ? 32'd0 : 32'(e.len - 2));
            chk("wr_strobe_len", 32'(wr_cnt), e.wr ? 32'(e.len - 2) : 32'd0);
            chk("data_oe_len", 32'(oe_cnt), e.wr ? 32'(e.len) : 32'd0);
            chk("bus_drive", 32'(bus_bad), 32'd0);
          end
          rd_cnt = 0; wr_cnt = 0; oe_cnt = 0; bus_bad = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d expected_finish=1", cyc);
    $fatal(1);
  end

  initial begin
    int   hs, hb, hprev, lprev, acks0;
    logic prev_b2b;
    vec_t v;

    // speed: 0 FAST, 1 SLOW, 2 XSLOW
    addv(24'h808000, 1'b0, 8'h00, 1'b0, 2'd1,  8, 8'h5A, 1'b0, 1'b0);
    addv(24'h808000, 1'b0, 8'h00, 1'b1, 2'd0,  6, 8'h5A, 1'b0, 1'b0);
    addv(24'hC00000, 1'b0, 8'h00, 1'b1, 2'd0,  6, 8'h9A, 1'b0, 1'b0);
    addv(24'h008000, 1'b0, 8'h00, 1'b1, 2'd1,  8, 8'hDA, 1'b0, 1'b0);
    addv(24'h008000, 1'b0, 8'h00, 1'b0, 2'd1,  8, 8'hDA, 1'b0, 1'b0);
    addv(24'h004016, 1'b1, 8'hA5, 1'b0, 2'd2, 12, 8'hDA, 1'b0, 1'b0);
    addv(24'h002100, 1'b1, 8'h3C, 1'b0, 2'd0,  6, 8'hDA, 1'b0, 1'b0);
    addv(24'h402000, 1'b0, 8'h00, 1'b1, 2'd1,  8, 8'h3A, 1'b0, 1'b0);
    addv(24'hFFFFFF, 1'b0, 8'h00, 1'b0, 2'd1,  8, 8'hA5, 1'b0, 1'b0);
    addv(24'h0041FF, 1'b0, 8'h00, 1'b0, 2'd2, 12, 8'hE4, 1'b0, 1'b0);
    addv(24'h001FFF, 1'b0, 8'h00, 1'b1, 2'd1,  8, 8'hBA, 1'b0, 1'b0);
    addv(24'h7E0000, 1'b0, 8'h00, 1'b0, 2'd1,  8, 8'h24, 1'b1, 1'b0);
    addv(24'h002000, 1'b0, 8'h00, 1'b0, 2'd0,  6, 8'h7A, 1'b1, 1'b0);
    addv(24'h004200, 1'b0, 8'h00, 1'b0, 2'd0,  6, 8'h18, 1'b0, 1'b0);
    addv(24'hC01234, 1'b0, 8'h00, 1'b1, 2'd0,  6, 8'hBC, 1'b0, 1'b1);
    addv(24'h808000, 1'b0, 8'h00, 1'b0, 2'd1,  8, 8'h5A, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_a_rd_n", 32'(a_rd_n), 32'd1);
    chk("rst_a_wr_n", 32'(a_wr_n), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ack_rdata", 32'(ack_rdata), 32'd0);
    chk("rst_a_addr", 32'(a_addr), 32'd0);
    chk("rst_a_wdata", 32'(a_wdata), 32'd0);
    chk("rst_a_data_oe", 32'(a_data_oe), 32'd0);
    chk("rst_cur_speed", 32'(cur_speed), 32'd0);
    chk("rst_refresh_busy", 32'(refresh_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef SFC_REFRESH_EN
    @(negedge clk);
    refresh_req = 1'b1;
    #1 chk("ignore_refresh_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    refresh_req = 1'b0;
    #1 chk("ignore_refresh_busy", 32'(refresh_busy), 32'd0);
`endif

    prev_b2b = 1'b0;
    hprev = 0;
    lprev = 0;
    foreach (vq[i]) begin
      send(vq[i], hs);
      if (prev_b2b && hs >= 0) chk("b2b_accept_gap", 32'(hs - hprev), 32'(lprev));
      hprev    = hs;
      lprev    = vq[i].len;
      prev_b2b = vq[i].b2b;
      if (!vq[i].b2b) begin
        @(negedge clk);
        req_valid = 1'b0;
        if (vq[i].tog) memsel = ~memsel;
        drain();
      end
    end

    // Reset in the middle of a slow read's strobe.
    v = vq[0];
    send(v, hs);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("abort_strobe_active", 32'(a_rd_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_a_rd_n", 32'(a_rd_n), 32'd1);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_ack", 32'(ack), 32'd0);
    q.delete();
    acks0 = ack_total;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_ack", 32'(ack_total - acks0), 32'd0);
    v = vq[4];
    send(v, hs);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

`ifdef SFC_REFRESH_EN
    busy_cnt = 0;
    busy_rdy = 0;
    v = vq[0];
    send(v, hs);
    fork
      begin
        repeat (3) @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
      end
      send(vq[1], hb);
    join
    chk("refresh_accept_cycle", 32'(hb - hs), 32'd49);
    chk("refresh_busy_len", 32'(busy_cnt), 32'd40);
    chk("refresh_ready_low", 32'(busy_rdy), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    @(negedge clk);
    refresh_req = 1'b1;
    req_valid   = 1'b1;
    req_addr    = vq[2].addr;
    req_write   = 1'b0;
    memsel      = 1'b1;
    #1 chk("refresh_wins_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    refresh_req = 1'b0;
    #1 chk("refresh_wins_busy", 32'(refresh_busy), 32'd1);
    send(vq[2], hs);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
